// File: rtl/acq_pkg.sv
// rtl/acq_pkg.sv - shared widths, queued word record and mask helper for the bit packer
package acq_pkg;

  localparam int WORD_W  = 31;
  localparam int NBITS_W = 5;
  localparam int LEN_W   = 16;

  typedef struct packed {
    logic [WORD_W-1:0]  word;
    logic [NBITS_W-1:0] nbits;
    logic               last;
  } acq_word_t;

  // Mask is rebuilt from nbits at the output rather than stored per entry.
  function automatic logic [WORD_W-1:0] nbits_to_mask(input logic [NBITS_W-1:0] n);
    logic [31:0] w_full_mask;
    w_full_mask   = (32'd1 << n) - 32'd1;
    nbits_to_mask = w_full_mask[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/acq_fifo2.sv
// rtl/acq_fifo2.sv - 2-entry synchronous FIFO of packed acquisition words
module acq_fifo2
  import acq_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  acq_word_t push_data,
  input  logic      pop,
  output acq_word_t head,
  output logic      full,
  output logic      empty,
  output logic [1:0] count
);

  acq_word_t  r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign w_pop  = pop & (r_count != 2'd0);
  assign w_push = push & ((r_count != 2'd2) | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign full  = (r_count == 2'd2);
  assign empty = (r_count == 2'd0);
  assign count = r_count;

endmodule

// File: rtl/acq_bit_packer.sv
// rtl/acq_bit_packer.sv - packs serial sample bits into 31-bit words for the popcount correlators
module acq_bit_packer
  import acq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_bit,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_word,
  output logic [WORD_W-1:0]  out_mask,
  output logic [NBITS_W-1:0] out_nbits,
  output logic               out_last,
  output logic [LEN_W-1:0]   word_count
);

  logic [WORD_W-1:0]  r_asm;
  logic [NBITS_W-1:0] r_ptr;
  logic [LEN_W-1:0]   r_word_count;

  logic               w_accept;
  logic               w_close;
  logic               w_pop;
  logic [WORD_W-1:0]  w_bit_vec;
  acq_word_t          w_push_data;
  acq_word_t          w_head;
  logic               w_full;
  logic               w_empty;
  logic [1:0]         w_count;

  assign in_ready  = (w_count < 2'd2);
  assign w_accept  = in_valid & in_ready;
  assign w_bit_vec = WORD_W'(in_bit) << r_ptr;
  assign w_close   = w_accept & ((r_ptr == NBITS_W'(WORD_W - 1)) | in_last);

  // The closing bit is merged combinationally so the word leaves on the same edge.
  assign w_push_data.word  = r_asm | w_bit_vec;
  assign w_push_data.nbits = r_ptr + NBITS_W'(1);
  assign w_push_data.last  = in_last;

  always_ff @(posedge clk) begin
    if (rst || w_close) begin
      r_asm <= '0;
      r_ptr <= '0;
    end else if (w_accept) begin
      r_asm <= r_asm | w_bit_vec;
      r_ptr <= r_ptr + NBITS_W'(1);
    end
  end

  acq_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_close & ~w_full),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;
  assign out_word  = w_head.word;
  assign out_nbits = w_head.nbits;
  assign out_last  = w_head.last;
  assign out_mask  = nbits_to_mask(w_head.nbits);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_count <= '0;
    end else if (w_pop) begin
      r_word_count <= w_head.last ? '0 : r_word_count + LEN_W'(1);
    end
  end

  assign word_count = r_word_count;

endmodule
